// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding, default width, clog2 helper.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle between a controller (master) and the serial subtractor (slave).
// start is a request with no ready: the slave silently ignores it while busy.
interface serial_subtractor_if
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  modport master (output start, a, b, input busy, done, diff, borrow);
  modport slave  (input start, a, b, output busy, done, diff, borrow);
endinterface

// File: rtl/serial_subtractor_fa.sv
// 1-bit full adder cell; used as the bit-slice of the serial datapath.
// Purely combinational, zero latency, no flow control.
module fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned a - b, LSB first, via a + ~b + 1 through one full adder cell.
// Latency WIDTH+1 cycles from accepted start to done; start is ignored while busy.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  serial_subtractor_if.slave io
);

  localparam int            CW   = clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_n;
  logic [WIDTH-1:0] diff_q;
  logic [CW-1:0]    count;
  logic             carry;
  logic             borrow_q;
  logic             sum;
  logic             cout;
  logic             accept;
  logic             step;
  logic             last;

  fa u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (sum),
    .cout (cout)
  );

  // New sum bit enters at the MSB; after WIDTH steps res holds the whole result.
  assign res_n = WIDTH'({sum, res} >> 1);

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    case (state)
      S_IDLE: begin
        if (io.start) begin
          accept  = 1'b1;
          state_n = S_SHIFT;
        end
      end
      S_SHIFT: begin
        step = 1'b1;
        if (count == LAST) begin
          last    = 1'b1;
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        if (io.start) begin
          accept  = 1'b1;
          state_n = S_SHIFT;
        end else begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      res      <= '0;
      carry    <= 1'b0;
      count    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        a_sh  <= io.a;
        b_sh  <= ~io.b;
        carry <= 1'b1;
        count <= '0;
        res   <= '0;
      end else if (step) begin
        a_sh  <= a_sh >> 1;
        b_sh  <= b_sh >> 1;
        carry <= cout;
        count <= count + CW'(1);
        res   <= res_n;
        // Outputs only change here, so they stay stable through the next operation.
        if (last) begin
          diff_q   <= res_n;
          borrow_q <= ~cout;
        end
      end
    end
  end

  assign io.busy   = (state == S_SHIFT);
  assign io.done   = (state == S_DONE);
  assign io.diff   = diff_q;
  assign io.borrow = borrow_q;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial unsigned subtractor computing diff = a - b over WIDTH clock cycles, LSB first.
- Built around the team's existing 1-bit full adder cell, using the two's-complement identity a + ~b + 1. It is the subtract direction of the adder datapath.
- Start/busy/done handshake lets a controller or bench launch operations and wait for the result.
- Sits next to the full-adder blocks as the sequential arithmetic unit for narrow datapaths.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to begin a subtraction; sampled on the rising edge of clk.
- a  input  WIDTH  minuend; captured only on an accepted start.
- b  input  WIDTH  subtrahend; captured only on an accepted start.
- busy  output  1  high while a subtraction is in progress (SHIFT state).
- done  output  1  one-cycle pulse; diff and borrow are valid from this cycle onward.
- diff  output  WIDTH  result, (a - b) mod 2^WIDTH.
- borrow  output  1  1 when a < b (unsigned); equals the inverted final carry.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, busy=0, done=0, diff=0, borrow=0. Internal shift registers, carry and counter are cleared.
- States: IDLE, SHIFT, DONE.
- IDLE: busy=0, done=0. When start=1, capture a into a_sh and ~b into b_sh, set carry=1, count=0, go to SHIFT.
- SHIFT: busy=1. Each cycle, the full-adder cell takes a_sh[0], b_sh[0] and carry.
  - Its sum shifts into the MSB of the result register; the result shifts right.
  - a_sh and b_sh shift right; carry takes the cell's carry-out; count increments.
  - When count reaches WIDTH-1, the final bit is processed on that edge and the FSM goes to DONE.
  - start is ignored throughout SHIFT.
- DONE: lasts exactly one cycle. busy=0, done=1, diff=full result register, borrow=~carry.
  - If start=1 in DONE, a new operation is accepted (back-to-back): operands are captured and the FSM goes to SHIFT.
  - Otherwise the FSM goes to IDLE.
- Latency: start sampled at edge E0; bits are processed on edges E1..E(WIDTH); done is high in the cycle following edge E(WIDTH), i.e. WIDTH+1 cycles after the start edge.
- Throughput: one result per WIDTH+1 cycles.
- diff and borrow hold their last values until the next DONE, or until reset. They are not disturbed during SHIFT: compute in an internal shift register and load diff/borrow on the DONE transition.
- Changes on a or b after an accepted start have no effect on the result in progress.
- Width rules: count width is clog2(WIDTH). The full-adder carry chain is exactly 1 bit. No saturation; the result wraps modulo 2^WIDTH.
- Reset asserted mid-operation aborts immediately to the reset values; no done pulse is generated for the aborted operation.
- start held high continuously: one operation per WIDTH+1 cycles, accepted in IDLE or DONE only.

Decomposition:
- Shared header serial_sub_defs.vh (team package equivalent) holds:
  - state encodings: S_IDLE=2'd0, S_SHIFT=2'd1, S_DONE=2'd2;
  - default WIDTH;
  - the clog2 helper function.
- One sub-module: instantiate the existing full-adder cell fa (ports a, b, cin, sum, cout) as the serial bit-slice.
- The control FSM, counter and shift registers stay in serial_subtractor.

Test Plan:
- WIDTH=8, a=5, b=3, pulse start -> busy for 8 cycles; done pulses 9 cycles after the start edge; diff=8'h02, borrow=0.
- a=3, b=5 -> diff=8'hFE, borrow=1.
- Corner cases:
  - a=8'h00, b=8'hFF -> diff=8'h01, borrow=1.
  - a=8'hFF, b=8'h01 -> diff=8'hFE, borrow=0.
  - a=b=0 -> diff=0, borrow=0.
- Start 5-3, then assert start with a=9, b=1 and change a/b during SHIFT -> second start ignored; result still diff=2, borrow=0, one done pulse only.
- Hold start high with a=10, b=4 -> done pulses every 9 cycles; diff=8'h06 each time; busy low only in DONE cycles.
- Assert rst 4 cycles into an operation (start 7-2) -> busy, done, diff and borrow drop to 0 immediately; no done pulse follows. A new start 7-2 after reset release yields diff=5, borrow=0.
